// File: rtl/oaum_pkg.sv
// Shared constants and helpers for the mantissa OAUM pipeline:
// correction-constant table, level clamp and internal sum width.
package oaum_pkg;

    localparam int SUM_INT_W = 3;
    // Widest legal sum: 3 integer bits + 32 fraction bits + 4 levels.
    localparam int MAX_SUM_W = SUM_INT_W + 32 + 4;

    function automatic int oaum_sum_w(input int mw, input int max_lvl);
        return SUM_INT_W + mw + max_lvl;
    endfunction

    function automatic int oaum_clamp_lvl(input int lvl, input int max_lvl);
        return (lvl > max_lvl) ? max_lvl : lvl;
    endfunction

    // C[0] = 0, C[l] = 2^-(2l), expressed with frac_w fraction bits.
    function automatic logic [MAX_SUM_W-1:0] oaum_c_val(input int lvl, input int frac_w);
        if (lvl <= 0) return '0;
        return MAX_SUM_W'(1) << (frac_w - 2 * lvl);
    endfunction

endpackage

// File: rtl/oaum_csa_tree.sv
// Combinational 3:2 carry-save reduction of N W-bit terms into sum/carry
// vectors. Arithmetic is modulo 2^W; callers size W so the true sum fits.
module oaum_csa_tree #(
    parameter int W = 8,
    parameter int N = 3
) (
    input  logic [N-1:0][W-1:0] i_terms,
    output logic [W-1:0]        o_sum,
    output logic [W-1:0]        o_carry
);

    logic [W-1:0] w_s;
    logic [W-1:0] w_c;
    logic [W-1:0] w_t;

    always_comb begin
        w_s = i_terms[0];
        w_c = i_terms[1];
        w_t = '0;
        for (int k = 2; k < N; k++) begin
            w_t = w_s ^ w_c ^ i_terms[k];
            w_c = ((w_s & w_c) | (w_s & i_terms[k]) | (w_c & i_terms[k])) << 1;
            w_s = w_t;
        end
    end

    assign o_sum   = w_s;
    assign o_carry = w_c;

endmodule

// File: rtl/mantissa_oaum_pipe.sv
// Two-stage approximate mantissa adder: CSA reduction, then CPA + normalise.
// Define OAUM_ROUND_EN for round-half-up (saturating) instead of truncation.
module mantissa_oaum_pipe
    import oaum_pkg::*;
#(
    parameter int MANTISSA_WIDTH = 15,
    parameter int MAX_LEVEL      = 2,
    parameter int LVL_W          = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANTISSA_WIDTH-1:0] mantissa_x,
    input  logic [MANTISSA_WIDTH-1:0] mantissa_y,
    input  logic [LVL_W-1:0]          acc_lvl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MANTISSA_WIDTH-1:0] mantissa_out,
    output logic [1:0]                shift,
    output logic                      busy
);

    localparam int MW = MANTISSA_WIDTH;
    localparam int FW = MW + MAX_LEVEL;
    localparam int SW = oaum_sum_w(MW, MAX_LEVEL);
    localparam int NT = 2 * MAX_LEVEL + 3;

    logic                r_s1_valid;
    logic [SW-1:0]       r_s1_sum;
    logic [SW-1:0]       r_s1_carry;
    logic                r_out_valid;
    logic [MW-1:0]       r_mant;
    logic [1:0]          r_shift;

    logic                w_s2_load;
    logic                w_s1_load;
    int                  w_le;
    logic [NT-1:0][SW-1:0] w_terms;
    logic [SW-1:0]       w_csa_sum;
    logic [SW-1:0]       w_csa_carry;
    logic [1:0]          w_shift;
    logic [MW-1:0]       w_mant;
    logic [MW-1:0]       w_mant_fin;

    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // Disabled levels contribute zero so the tree shape is fixed by MAX_LEVEL.
    always_comb begin
        w_le    = oaum_clamp_lvl(int'(acc_lvl), MAX_LEVEL);
        w_terms = '0;
        w_terms[0] = SW'(mantissa_x) << MAX_LEVEL;
        w_terms[1] = SW'(mantissa_y) << MAX_LEVEL;
        for (int l = 1; l <= MAX_LEVEL; l++) begin
            if (l <= w_le) begin
                w_terms[2*l]   = SW'(mantissa_x) << (MAX_LEVEL - l);
                w_terms[2*l+1] = SW'(mantissa_y) << (MAX_LEVEL - l);
            end
        end
        w_terms[NT-1] = SW'(oaum_c_val(w_le, FW));
    end

    oaum_csa_tree #(.W(SW), .N(NT)) u_csa (
        .i_terms (w_terms),
        .o_sum   (w_csa_sum),
        .o_carry (w_csa_carry)
    );

    // Window = 3 integer bits + MW fraction bits (+ round bit when rounding).
`ifdef OAUM_ROUND_EN
    localparam int RB = 1;
    localparam int WIN_W = MW + 4;
    logic [WIN_W-1:0] w_win;
    assign w_win = WIN_W'(({r_s1_sum, 1'b0} + {r_s1_carry, 1'b0}) >> MAX_LEVEL);
`else
    localparam int RB = 0;
    localparam int WIN_W = MW + 3;
    logic [WIN_W-1:0] w_win;
    assign w_win = WIN_W'((r_s1_sum + r_s1_carry) >> MAX_LEVEL);
`endif

    always_comb begin
        if (w_win[WIN_W-1])      w_shift = 2'd2;
        else if (w_win[WIN_W-2]) w_shift = 2'd1;
        else                     w_shift = 2'd0;
        case (w_shift)
            2'd2:    w_mant = w_win[RB+2 +: MW];
            2'd1:    w_mant = w_win[RB+1 +: MW];
            default: w_mant = w_win[RB +: MW];
        endcase
    end

`ifdef OAUM_ROUND_EN
    logic          w_rbit;
    logic [MW:0]   w_rnd;
    always_comb begin
        case (w_shift)
            2'd2:    w_rbit = w_win[2];
            2'd1:    w_rbit = w_win[1];
            default: w_rbit = w_win[0];
        endcase
        w_rnd      = {1'b0, w_mant} + {{MW{1'b0}}, w_rbit};
        w_mant_fin = w_rnd[MW] ? {MW{1'b1}} : w_rnd[MW-1:0];
    end
`else
    assign w_mant_fin = w_mant;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_mant      <= '0;
            r_shift     <= '0;
        end else begin
            if (w_s1_load) r_s1_valid <= in_valid;
            if (w_s2_load) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_mant  <= w_mant_fin;
                    r_shift <= w_shift;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_load && in_valid) begin
            r_s1_sum   <= w_csa_sum;
            r_s1_carry <= w_csa_carry;
        end
    end

    assign out_valid    = r_out_valid;
    assign mantissa_out = r_mant;
    assign shift        = r_shift;
    assign busy         = r_s1_valid || r_out_valid;

endmodule

// File: tb/tb_mantissa_oaum_pipe.sv
// Self-checking bench for mantissa_oaum_pipe (MANTISSA_WIDTH=8, MAX_LEVEL=2);
// expectations follow OAUM_ROUND_EN when the build defines it.
module tb_mantissa_oaum_pipe;

    localparam int TMW = 8;
    localparam int TML = 2;
    localparam int TFW = TMW + TML;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mantissa_x;
    logic [7:0] mantissa_y;
    logic [2:0] acc_lvl;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] mantissa_out;
    logic [1:0] shift;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [9:0] q[$];

    always #5 clk = ~clk;

    mantissa_oaum_pipe #(.MANTISSA_WIDTH(8), .MAX_LEVEL(2), .LVL_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mantissa_x(mantissa_x), .mantissa_y(mantissa_y), .acc_lvl(acc_lvl),
        .out_valid(out_valid), .out_ready(out_ready), .mantissa_out(mantissa_out),
        .shift(shift), .busy(busy)
    );

    // Exact sum scaled by 2^TFW, then normalise on the integer value.
    function automatic logic [9:0] model(input int x, input int y, input int lvl);
        int le; int ip; int sh; longint s; longint m;
        le = (lvl > TML) ? TML : lvl;
        s = longint'(x + y) * (longint'(1) << TML);
        for (int l = 1; l <= le; l++) s += longint'(x + y) * (longint'(1) << (TML - l));
        if (le > 0) s += longint'(1) << (TFW - 2 * le);
        ip = int'(s >> TFW);
        sh = (ip >= 4) ? 2 : ((ip >= 2) ? 1 : 0);
        m = (s >> (TFW + sh - TMW)) % 256;
`ifdef OAUM_ROUND_EN
        if (((s >> (TFW + sh - TMW - 1)) & 1) != 0) m = (m == 255) ? 255 : m + 1;
`endif
        return {2'(sh), 8'(m)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mantissa_x = '0; mantissa_y = '0; acc_lvl = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++; $display("FAIL reset_flags: got v/b/r=%b expected 001", {out_valid, busy, in_ready});
        end
        checks++;
        if ({shift, mantissa_out} !== 10'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 000", {shift, mantissa_out});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++; $display("FAIL idle_after_reset: got %b expected 001", {out_valid, busy, in_ready});
        end
    endtask

    task automatic test_directed();
        logic [7:0] c1 = 8'hC1;
        logic [7:0] d1 = 8'hD1;
        int vx[6] = '{'h80, 'hFF, 'h81, 'h81, 'h81, 'h10};
        int vy[6] = '{'h80, 'hFF, 'h80, 'h80, 'h80, 'h20};
        int vl[6] = '{1, 2, 1, 2, 7, 0};
        int es[6] = '{0, 1, 0, 0, 0, 0};
        logic [7:0] em[6];
`ifdef OAUM_ROUND_EN
        c1 = 8'hC2; d1 = 8'hD2;
`endif
        em = '{8'hC0, 8'hC6, c1, d1, d1, 8'h30};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            mantissa_x = 8'(vx[i]); mantissa_y = 8'(vy[i]); acc_lvl = 3'(vl[i]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL dir%0d_early: out_valid %b expected 0 after 1 cycle", i, out_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || mantissa_out !== em[i] || shift !== 2'(es[i])) begin
                errors++;
                $display("FAIL dir%0d_result: got v=%b m=%h s=%0d expected v=1 m=%h s=%0d",
                         i, out_valid, mantissa_out, shift, em[i], es[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    // rnd=0: continuous input, out_ready 1,0,1,0...; rnd=1: random valid/ready.
    task automatic test_stream(input int nbeats, input bit rnd);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit acc = 1'b1;
        bit stalled = 1'b0;
        logic [9:0] prev = '0;
        logic [9:0] exp_v;
        logic exp_rdy;
        q.delete();
        while (got < nbeats && cyc < 3000) begin
            if (acc) begin
                if (sent < nbeats && (!rnd || $urandom_range(3) != 0)) begin
                    in_valid = 1'b1;
                    mantissa_x = 8'($urandom); mantissa_y = 8'($urandom); acc_lvl = 3'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = rnd ? 1'($urandom_range(1)) : (cyc % 2 == 0);
            #4;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {shift, mantissa_out} !== prev) begin
                    errors++; $display("FAIL stall_hold: got v=%b %h expected v=1 %h", out_valid, {shift, mantissa_out}, prev);
                end
            end
            exp_rdy = !(q.size() == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL in_ready: got %b expected %b (inflight %0d)", in_ready, exp_rdy, q.size());
            end
            checks++;
            if (busy !== (q.size() != 0)) begin
                errors++; $display("FAIL busy: got %b expected %b", busy, q.size() != 0);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL spurious_out: got %h expected none", {shift, mantissa_out});
                end else begin
                    exp_v = q.pop_front();
                    if ({shift, mantissa_out} !== exp_v) begin
                        errors++; $display("FAIL stream_result%0d: got %h expected %h", got, {shift, mantissa_out}, exp_v);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(int'(mantissa_x), int'(mantissa_y), int'(acc_lvl)));
                sent++;
                acc = 1'b1;
            end else begin
                acc = !in_valid;
            end
            stalled = out_valid && !out_ready;
            prev = {shift, mantissa_out};
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != nbeats) begin
            errors++; $display("FAIL stream_timeout: got %0d results expected %0d", got, nbeats);
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b1;
        in_valid = 1'b1; mantissa_x = 8'h80; mantissa_y = 8'h80; acc_lvl = 3'd1;
        @(posedge clk); #1;
        mantissa_x = 8'hFF; mantissa_y = 8'hFF; acc_lvl = 3'd2;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++; $display("FAIL inflight_reset: got v/b/r=%b expected 001", {out_valid, busy, in_ready});
        end
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL discarded_beat%0d: got v=%b b=%b expected 0 0", i, out_valid, busy);
            end
        end
        in_valid = 1'b1; mantissa_x = 8'hFF; mantissa_y = 8'hFF; acc_lvl = 3'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_early: got %b expected 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || mantissa_out !== 8'hC6 || shift !== 2'd1) begin
            errors++; $display("FAIL post_reset_beat: got v=%b m=%h s=%0d expected v=1 m=c6 s=1",
                               out_valid, mantissa_out, shift);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream(16, 1'b0);
        test_stream(300, 1'b1);
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
